prog_count_timer: RTL

- Parametrised successor to the fixed 8 ms debounce timer.
- Counts clock cycles up to a runtime-loadable terminal count and has two modes: one-shot (latched expiry level) and periodic (auto-reload with a per-period pulse).
- Supports hold/pause, explicit stop and a saturating expiry counter.
- Sits between the button-cleanup state machines and any logic that needs programmable delays or tick generation.

---
 rtl/prog_count_timer_if.sv | 29 ++
 rtl/prog_count_timer.sv | 101 ++++++++++
 2 files changed

// File: rtl/prog_count_timer_if.sv
// Control/status bundle for the programmable count timer.
interface prog_count_timer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned EXP_W = 8
);
  logic             timerStart;
  logic             timerStop;
  logic             timerHold;
  logic             mode;
  logic             tcLoad;
  logic [WIDTH-1:0] tcIn;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             timerOut;
  logic             tick;
  logic [EXP_W-1:0] expCount;

  // Requester side: drives controls, observes status.
  modport master (
    output timerStart, timerStop, timerHold, mode, tcLoad, tcIn,
    input  count, busy, timerOut, tick, expCount
  );

  // Timer side: consumes controls, drives status.
  modport slave (
    input  timerStart, timerStop, timerHold, mode, tcLoad, tcIn,
    output count, busy, timerOut, tick, expCount
  );
endinterface

// File: rtl/prog_count_timer.sv
// Programmable cycle timer: one-shot (latched expiry) or periodic (auto-reload
// with per-period tick), with hold, stop and a saturating expiry counter.
module prog_count_timer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEFAULT_TC = 39999,
  parameter int unsigned EXP_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  prog_count_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] count, countNext;
  logic [WIDTH-1:0] tc, tcNext;
  logic             modeReg, modeNext;
  logic [EXP_W-1:0] expCount, expNext;
  logic             atTerminal;
  logic             tickC;

  // State and datapath registers; synchronous reset restores defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= WIDTH'(DEFAULT_TC);
      modeReg  <= 1'b0;
      expCount <= '0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      tc       <= tcNext;
      modeReg  <= modeNext;
      expCount <= expNext;
    end
  end

  // Next-state and datapath: stop beats start beats normal counting.
  always_comb begin
    stateNext  = state;
    countNext  = count;
    modeNext   = modeReg;
    expNext    = expCount;
    tcNext     = bus.tcLoad ? bus.tcIn : tc;
    // >= keeps a lowered terminal count from letting count run away and wrap.
    atTerminal = (count >= tc);
    tickC      = (state == RUN) && !bus.timerHold && atTerminal;

    if (bus.timerStop) begin
      stateNext = IDLE;
      countNext = '0;
      expNext   = '0;
    end else if (bus.timerStart) begin
      stateNext = RUN;
      countNext = '0;
      expNext   = '0;
      modeNext  = bus.mode;
    end else begin
      case (state)
        IDLE: begin
          countNext = '0;
        end
        RUN: begin
          if (!bus.timerHold) begin
            if (!atTerminal) begin
              countNext = count + WIDTH'(1);
            end else if (modeReg) begin
              countNext = '0;
              if (expCount != {EXP_W{1'b1}}) begin
                expNext = expCount + EXP_W'(1);
              end
            end else begin
              stateNext = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          countNext = count;
        end
        default: begin
          stateNext = IDLE;
          countNext = '0;
        end
      endcase
    end
  end

  // Status decode; busy/timerOut come straight from the state register.
  assign bus.count    = count;
  assign bus.busy     = (state == RUN);
  assign bus.timerOut = (state == EXPIRED);
  assign bus.tick     = tickC;
  assign bus.expCount = expCount;

endmodule
